// File: rtl/task_sched_pkg.sv
// task_sched_pkg: FSM state enum, status codes and status-word packing shared by task_scheduler
package task_sched_pkg;
  typedef enum logic [2:0] {IDLE, DISPATCH, DROP, WAIT, STATUS} state_e;
  localparam logic [7:0] CODE_OK       = 8'd0;
  localparam logic [7:0] CODE_BAD_ID   = 8'd1;
  localparam logic [7:0] CODE_TIMEOUT  = 8'd2;
  localparam logic [7:0] CODE_BAD_LEN  = 8'd3;
  localparam logic [7:0] CODE_OVERFLOW = 8'd4;
  localparam logic [7:0] STATUS_MAGIC  = 8'hA5;
  function automatic logic [31:0] pack_status(input logic [7:0] id, input logic [7:0] code, input logic [7:0] cnt);
    return {STATUS_MAGIC, id, code, cnt};
  endfunction
endpackage

// File: rtl/task_scheduler_fifo.sv
// result_fifo: sync FIFO (clk, rst, push/din in, pop in, dout/full/empty out), head read from the register array, push+pop allowed when full
module result_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/task_scheduler.sv
// task_scheduler: request framer (i_valid/i_first/i_last/i_data -> o_ready) to one-hot task bus (o_task_*), task results (i_task_*) buffered to TX (o_valid/o_last/o_data <- i_ready) plus status word; o_busy, sticky o_err
module task_scheduler
  import task_sched_pkg::*;
#(
  parameter int N_TASKS = 16,
  parameter int TASK_INPUT_WIDTH = 32,
  parameter int TASK_OUTPUT_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  input  logic                                 i_first,
  input  logic                                 i_last,
  input  logic [TASK_INPUT_WIDTH-1:0]          i_data,
  output logic                                 o_ready,
  output logic [N_TASKS-1:0]                   o_task_valid,
  output logic                                 o_task_first,
  output logic                                 o_task_last,
  output logic [TASK_INPUT_WIDTH-1:0]          o_task_data,
  input  logic [N_TASKS-1:0]                   i_task_valid,
  input  logic [N_TASKS-1:0]                   i_task_last,
  input  logic [N_TASKS*TASK_OUTPUT_WIDTH-1:0] i_task_data,
  output logic                                 o_valid,
  output logic                                 o_last,
  output logic [TASK_OUTPUT_WIDTH-1:0]         o_data,
  input  logic                                 i_ready,
  output logic                                 o_busy,
  output logic                                 o_err
);
  localparam int OW = TASK_OUTPUT_WIDTH;
  localparam int IW = N_TASKS > 1 ? $clog2(N_TASKS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [7:0] id_q, id_d, code_q, code_d, cnt_q, cnt_d, fcode;
  logic ovf_q, ovf_d, done_q, done_d, err_q, err_d, first_q, first_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [N_TASKS-1:0] tv_q, tv_d;
  logic tf_q, tf_d, tl_q, tl_d;
  logic [TASK_INPUT_WIDTH-1:0] td_q, td_d;
  logic [IW-1:0] idx;
  logic acc, cap, cap_last, push, pop, full, empty, stat;
  logic [OW-1:0] head;
  assign idx = id_q[IW-1:0];
  assign o_ready = !i_rst && (state_q == IDLE || state_q == DISPATCH || state_q == DROP);
  assign acc = i_valid && o_ready;
  assign cap = (state_q == DISPATCH || state_q == WAIT) && i_task_valid[idx];
  assign cap_last = cap && i_task_last[idx];
  assign stat = state_q == STATUS && empty;
  assign pop = !empty && i_ready;
  assign push = cap && (!full || pop);
  assign fcode = code_q != CODE_OK ? code_q : ovf_q ? CODE_OVERFLOW : CODE_OK;
  assign o_valid = !empty || stat;
  assign o_last = stat;
  assign o_data = stat ? OW'(pack_status(id_q, fcode, cnt_q)) : empty ? '0 : head;
  assign o_busy = state_q != IDLE;
  assign o_err = err_q;
  assign o_task_valid = tv_q;
  assign o_task_first = tf_q;
  assign o_task_last = tl_q;
  assign o_task_data = td_q;
  result_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_rst), .push(push), .din(i_task_data[idx*OW +: OW]),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    code_d = code_q;
    cnt_d = push ? cnt_q + 8'd1 : cnt_q;
    ovf_d = ovf_q | (cap && !push);
    done_d = done_q | cap_last;
    err_d = err_q | (stat && fcode != CODE_OK);
    first_d = first_q;
    tmo_d = (state_q == WAIT && !cap) ? tmo_q + CW'(1) : '0;
    tv_d = '0;
    tf_d = 1'b0;
    tl_d = 1'b0;
    td_d = td_q;
    case (state_q)
      IDLE: if (acc) begin
        if (!i_first) err_d = 1'b1;
        else begin
          id_d = i_data[7:0];
          code_d = CODE_OK;
          cnt_d = '0;
          ovf_d = 1'b0;
          done_d = 1'b0;
          first_d = 1'b1;
          if ({24'd0, i_data[7:0]} >= 32'(N_TASKS)) begin
            code_d = CODE_BAD_ID;
            state_d = i_last ? STATUS : DROP;
          end else if (i_last) begin
            code_d = CODE_BAD_LEN;
            state_d = STATUS;
          end else state_d = DISPATCH;
        end
      end
      DISPATCH: if (acc) begin
        tv_d = N_TASKS'(1) << idx;
        tf_d = first_q;
        tl_d = i_last;
        td_d = i_data;
        first_d = 1'b0;
        if (i_last) state_d = WAIT;
      end
      DROP: if (acc && i_last) state_d = STATUS;
      WAIT: if (done_q || cap_last) state_d = STATUS;
        else if (!cap && tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
          code_d = CODE_TIMEOUT;
          state_d = STATUS;
        end
      STATUS: if (stat && i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      id_q <= '0;
      code_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      first_q <= 1'b0;
      tmo_q <= '0;
      tv_q <= '0;
      tf_q <= 1'b0;
      tl_q <= 1'b0;
      td_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      err_q <= err_d;
      first_q <= first_d;
      tmo_q <= tmo_d;
      tv_q <= tv_d;
      tf_q <= tf_d;
      tl_q <= tl_d;
      td_q <= td_d;
    end
  end
endmodule

// File: doc/task_scheduler.md
Name: task_scheduler

Overview:
- Sits between the UART RX/TX framers and the N task slots (task_00..task_NN).
- Accepts one framed request at a time: the header word selects the task and the payload is dispatched to that task only.
- Task result words are buffered and forwarded to TX, followed by a trailing status word.
- Serialises access to the tasks, enforces a result timeout, and reports framing and ID errors.

Parameters:
- N_TASKS, 16, number of task slots; legal IDs are 0..N_TASKS-1.
- TASK_INPUT_WIDTH, 32, width of request words and of the task input data.
- TASK_OUTPUT_WIDTH, 32, width of result and status words; must be >= 32.
- FIFO_DEPTH, 16, result FIFO depth; must be a power of 2.
- TIMEOUT_CYCLES, 65536, idle cycles allowed while awaiting task output.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request word valid.
- i_first  in  1  request header word.
- i_last  in  1  final request word.
- i_data  in  TASK_INPUT_WIDTH  request word.
- o_ready  out  1  request word accepted when i_valid && o_ready.
- o_task_valid  out  N_TASKS  one-hot payload valid to the tasks.
- o_task_first  out  1  first payload word, shared.
- o_task_last  out  1  last payload word, shared.
- o_task_data  out  TASK_INPUT_WIDTH  payload, shared.
- i_task_valid  in  N_TASKS  per-task result valid.
- i_task_last  in  N_TASKS  per-task result last.
- i_task_data  in  N_TASKS*TASK_OUTPUT_WIDTH  per-task result, task k at slice [k*W +: W].
- o_valid  out  1  TX word valid.
- o_last  out  1  TX word is the status word.
- o_data  out  TASK_OUTPUT_WIDTH  TX word.
- i_ready  in  1  TX accepts the word.
- o_busy  out  1  FSM not IDLE.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. Reset mid-frame abandons the frame without emitting status; the tasks share i_rst.
- States and transitions:
  - IDLE: o_ready=1. A word with i_first latches id=i_data[7:0].
    - If id >= N_TASKS: go to DROP, code=BAD_ID. If i_last is also set, go straight to STATUS.
    - Header with i_last and a valid id: go to STATUS, code=BAD_LEN.
    - Otherwise: go to DISPATCH.
    - A valid word without i_first: dropped, o_err set.
  - DISPATCH: o_ready=1. Each accepted word drives the task bus one cycle later through one register stage.
    - o_task_valid[id]=1.
    - o_task_first=1 on the first payload word only.
    - o_task_last=i_last.
    - When i_last is accepted, go to WAIT.
  - DROP: o_ready=1. Words are discarded until i_last, then go to STATUS.
  - WAIT: o_ready=0. The timeout counter runs.
    - i_task_valid[id] && i_task_last[id] marks done and goes to STATUS.
    - Counter reaching TIMEOUT_CYCLES sets code=TIMEOUT and goes to STATUS.
  - STATUS: o_ready=0. Waits for the FIFO to empty, then presents the status word with o_last=1.
    - On i_ready, return to IDLE.
- Timeout counter: cleared on entry to WAIT and on each result word from the active task.
- Result capture:
  - Active in DISPATCH and WAIT, because tasks may answer before their input ends.
  - Only i_task_*[id] is captured; the other tasks' outputs, and any output outside DISPATCH/WAIT, are discarded.
  - Each captured word is pushed to the FIFO and increments an 8-bit result count, which wraps.
  - Pushing while full drops the word and flags overflow.
- TX output:
  - The FIFO head drives o_data with o_last=0, and pops on o_valid && i_ready.
  - A captured word appears on o_valid at the earliest 1 cycle after capture.
  - o_valid/o_data hold while i_ready=0.
  - Pop and push in the same cycle is legal when full.
- Status word:
  - [31:24]=8'hA5, [23:16]=id, [15:8]=code, [7:0]=count. Upper bits above 31 are 0.
  - Codes: OK=0, BAD_ID=1, TIMEOUT=2, BAD_LEN=3, OVERFLOW=4.
  - Precedence: BAD_ID/BAD_LEN > TIMEOUT > OVERFLOW > OK.
- o_err: set on any non-OK code or a stray word; cleared only by i_rst.
- Minimum request latency: header accepted at T, first payload accepted at T+1, visible on the task bus at T+2.

Decomposition:
- Package task_sched_pkg holds:
  - the state enum (IDLE, DISPATCH, DROP, WAIT, STATUS);
  - the status code localparams and STATUS_MAGIC=8'hA5;
  - the status-word packing function.
- One sub-module, result_fifo: a synchronous FIFO with full/empty, registered output, and simultaneous push/pop.

Test Plan:
- Header 0x00000003 then payloads 0x11, 0x22 (last); task 3 returns 0xAA, 0xBB (last).
  - Task bus: valid[3] with 0x11 (first), then 0x22 (last).
  - TX: 0xAA, 0xBB, then 0xA5030002 with o_last.
- Header 0x000000FF, N_TASKS=16, with 2 payload words: no o_task_valid; TX 0xA5FF0100 last; o_err=1.
- Header 0x00000001 plus 1 payload; task silent; TIMEOUT_CYCLES=100: status 0xA5010200 exactly 100 cycles after WAIT entry.
- i_ready=0 while the task emits 20 words, FIFO_DEPTH=16: TX delivers 16 words, then 0xA5xx0410.
- Task 5 active while task 2 asserts valid: task 2 words absent from TX. A new header during WAIT is held off by o_ready=0.
- i_rst pulsed mid-DISPATCH: next cycle o_busy=0, o_valid=0, FIFO empty; a following clean request completes with OK.
